display_scan_counter: RTL and testbench

//   Digit-scan sequencer for the coffee-machine 4-digit 7-segment display. Divides the system

---
 rtl/coffee_display_pkg.sv | 18 +
 rtl/display_scan_counter_prescaler.sv | 37 +++
 rtl/display_scan_counter.sv | 89 ++++++++
 tb/tb_display_scan_counter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/coffee_display_pkg.sv
// Shared display definitions: digit count, scan index type and the anode decode.
package coffee_display_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   typedef logic [1:0] digit_idx_t;

   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

   // Active-low one-hot anode for the given digit.
   function automatic logic [NUM_DIGITS-1:0] idx_to_anode(input digit_idx_t idx);
      logic [NUM_DIGITS-1:0] an;
      an      = ANODE_OFF;
      an[idx] = 1'b0;
      return an;
   endfunction

endpackage

// File: rtl/display_scan_counter_prescaler.sv
// Slot timer: counts 0..DIV-1 with clear/freeze and flags the terminal count.
module scan_prescaler #(
   parameter int unsigned DIV = 8,
   parameter int unsigned CW  = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic          freeze_i,
   output logic [CW-1:0] cnt_nxt_c,
   output logic          term_c
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_nxt_c;
   end

   // Clear dominates freeze; terminal pulse only when the count actually wraps.
   always_comb begin
      cnt_nxt_c = cnt_q;
      term_c    = 1'b0;
      if (clear_i) begin
         cnt_nxt_c = '0;
      end else if (!freeze_i) begin
         if (cnt_q == CW'(DIV - 1)) begin
            cnt_nxt_c = '0;
            term_c    = 1'b1;
         end else begin
            cnt_nxt_c = cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/display_scan_counter.sv
// Digit-scan sequencer: slot timing, scan index, blanking guard and active-low anodes.
module display_scan_counter
   import coffee_display_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned SCAN_HZ      = 1_000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  hold,
   output logic                  saida1Contador,
   output logic                  saida2Contador,
   output logic [NUM_DIGITS-1:0] digit_an,
   output logic                  blank,
   output logic                  tick
);

   localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV < 2) begin : g_chk_div
      $fatal(1, "display_scan_counter: DIV must be at least 2");
   end
   if (BLANK_CYCLES >= DIV) begin : g_chk_blank
      $fatal(1, "display_scan_counter: BLANK_CYCLES must be below DIV");
   end
   if ((CLK_HZ % SCAN_HZ) != 0) begin : g_chk_ratio
      $fatal(1, "display_scan_counter: CLK_HZ must be a multiple of SCAN_HZ");
   end

   logic                  clear;
   logic                  freeze;
   logic [CW-1:0]         cnt_nxt;
   logic                  slot_end;

   digit_idx_t            idx_q,   idx_d;
   logic [NUM_DIGITS-1:0] an_q,    an_d;
   logic                  blank_q, blank_d;
   logic                  tick_q,  tick_d;

   assign clear  = !enable;
   assign freeze = enable && hold;

   scan_prescaler #(
      .DIV (DIV),
      .CW  (CW)
   ) u_prescaler (
      .clk       (clock),
      .rst_n     (reset_n),
      .clear_i   (clear),
      .freeze_i  (freeze),
      .cnt_nxt_c (cnt_nxt),
      .term_c    (slot_end)
   );

   // Outputs are derived from the next cnt/idx so the registers line up with the timer.
   always_comb begin
      idx_d   = idx_q;
      blank_d = 1'b1;
      an_d    = ANODE_OFF;
      tick_d  = slot_end;
      if (slot_end) idx_d = idx_q + digit_idx_t'(1);
      blank_d = clear || (cnt_nxt < CW'(BLANK_CYCLES));
      if (!blank_d) an_d = idx_to_anode(idx_d);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx_q   <= '0;
         an_q    <= ANODE_OFF;
         blank_q <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         an_q    <= an_d;
         blank_q <= blank_d;
         tick_q  <= tick_d;
      end
   end

   assign saida1Contador = idx_q[1];
   assign saida2Contador = idx_q[0];
   assign digit_an       = an_q;
   assign blank          = blank_q;
   assign tick           = tick_q;

endmodule

// File: tb/tb_display_scan_counter.sv
// Directed and random bench for display_scan_counter with DIV=8, BLANK_CYCLES=2.
module tb_display_scan_counter;

   logic       clock;
   logic       reset_n;
   logic       enable;
   logic       hold;
   logic       saida1Contador;
   logic       saida2Contador;
   logic [3:0] digit_an;
   logic       blank;
   logic       tick;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_cnt  = 0;
   int m_idx  = 0;
   bit m_tick = 0;

   logic [7:0] sb[$];
   logic [1:0] prev_idx = 2'b00;

   display_scan_counter #(
      .CLK_HZ       (8),
      .SCAN_HZ      (1),
      .BLANK_CYCLES (2)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .enable         (enable),
      .hold           (hold),
      .saida1Contador (saida1Contador),
      .saida2Contador (saida2Contador),
      .digit_an       (digit_an),
      .blank          (blank),
      .tick           (tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] obs_vec();
      return {saida1Contador, saida2Contador, digit_an, blank, tick};
   endfunction

   function automatic logic [7:0] exp_vec();
      logic [3:0] one;
      logic [3:0] an;
      logic [1:0] ix;
      one = 4'b0001;
      ix  = 2'(m_idx);
      an  = (m_cnt >= 2) ? ~(one << ix) : 4'b1111;
      return {ix, an, (m_cnt < 2), m_tick};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_idx  = 0;
      m_tick = 0;
   endtask

   // Drive one cycle, push the model prediction, then pop and compare after the edge.
   task automatic step(input logic en, input logic hd, input logic rn);
      logic [7:0] e;
      logic [7:0] o;
      enable  = en;
      hold    = hd;
      reset_n = rn;
      if (!rn) begin
         model_reset();
      end else if (!en) begin
         m_cnt  = 0;
         m_tick = 0;
      end else if (hd) begin
         m_tick = 0;
      end else if (m_cnt == 7) begin
         m_cnt  = 0;
         m_idx  = (m_idx + 1) % 4;
         m_tick = 1;
      end else begin
         m_cnt++;
         m_tick = 0;
      end
      sb.push_back(exp_vec());
      @(posedge clock);
      #1;
      e = sb.pop_front();
      o = obs_vec();
      chk("scan", o, e);
      chk("one_anode", 8'($countones(~digit_an) > 1), 8'h00);
      chk("lit_while_blank", 8'(blank && (digit_an != 4'b1111)), 8'h00);
      if ({saida1Contador, saida2Contador} != prev_idx)
         chk("idx_change_blank", 8'(blank), 8'h01);
      prev_idx = {saida1Contador, saida2Contador};
   endtask

   initial begin
      int n_ticks;
      int n_lit;
      int n_steps;

      reset_n = 1'b1;
      enable  = 1'b0;
      hold    = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("reset_state", obs_vec(), 8'b00_1111_1_0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      // Free run: 40 cycles, five slot boundaries
      n_ticks = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 1'b1);
         if (tick) n_ticks++;
      end
      chk("tick_count_40", 8'(n_ticks), 8'd5);
      chk("after_40", obs_vec(), 8'b01_1111_1_1);

      // Hold for 5 cycles at cnt=4 of idx=01
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
      chk("pre_hold", obs_vec(), 8'b01_1101_0_0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
      chk("in_hold", obs_vec(), 8'b01_1101_0_0);
      n_steps = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b1);
         n_steps++;
         if (tick) break;
      end
      chk("hold_release_steps", 8'(n_steps), 8'd4);
      chk("after_stretch", obs_vec(), 8'b10_1111_1_1);

      // Disable at cnt=5 of idx=10 with hold also asserted
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
      chk("pre_disable", obs_vec(), 8'b10_1011_0_0);
      step(1'b0, 1'b1, 1'b1);
      chk("disabled", obs_vec(), 8'b10_1111_1_0);
      n_lit = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b1);
         if (!blank) n_lit++;
      end
      chk("lit_after_enable", 8'(n_lit), 8'd6);
      chk("after_reenable", obs_vec(), 8'b11_1111_1_1);

      // Asynchronous reset between edges mid-slot
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("async_reset", obs_vec(), 8'b00_1111_1_0);
      prev_idx = 2'b00;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      chk("post_reset_blank", obs_vec(), 8'b00_1110_0_0);

      // Random enable/hold/reset stress
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 49) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
